// File: rtl/sky130_fd_io__hvclamp_trig_pkg.sv
// -----------------------------------------------------------------------------
// sky130_fd_io__hvclamp_trig_pkg
// Shared definitions for the HV clamp trigger: FSM state encoding, parameter
// defaults and internal timer widths.
// -----------------------------------------------------------------------------
package sky130_fd_io__hvclamp_trig_pkg;

  // Parameter defaults
  localparam int DEB_CYC_DEF  = 2;
  localparam int HOLD_CYC_DEF = 64;
  localparam int COOL_CYC_DEF = 16;
  localparam int CNT_W_DEF    = 8;

  // Timer widths: debounce covers 1..15, hold/cool cover 1..1023
  localparam int DEB_W  = 4;
  localparam int HOLD_W = 10;
  localparam int COOL_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_FIRE     = 2'd2,
    ST_COOL     = 2'd3
  } state_t;

endpackage

// File: rtl/sky130_fd_io__hvclamp_trig_sync.sv
// -----------------------------------------------------------------------------
// sky130_fd_io__hvclamp_trig_sync
// Two-flop synchronizer bringing the asynchronous ramp detector into clk.
//
// Ports
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output (two clk edges of latency)
// -----------------------------------------------------------------------------
module sky130_fd_io__hvclamp_trig_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  // Stage 0: metastability capture; stage 1: settled output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/sky130_fd_io__hvclamp_trig.sv
// -----------------------------------------------------------------------------
// sky130_fd_io__hvclamp_trig
// Trigger for the HV rail ESD clamp. A fast-ramp detect, once synchronized and
// debounced for DEB_CYC cycles, turns the clamp gate on. The gate stays on for
// HOLD_CYC clocks after the last detect, then a COOL_CYC lockout follows during
// which detects are ignored.
//
// Optional feature: define SKY130_FD_IO_HVCLAMP_TRIG_EVTCNT_EN to build the
// saturating fire-event counter. Without it evt_cnt is tied to 0 and evt_clr is
// ignored (ports are kept).
//
// Ports
//   clk      : sole clock, rising edge
//   rst_n    : asynchronous active-low reset
//   en       : trigger enable; low forces IDLE and clears timers
//   ramp_det : asynchronous raw ramp detector
//   force_on : test override, forces ogc_en high without touching the FSM
//   evt_clr  : event counter clear
//   ogc_en   : registered clamp gate-control enable
//   cooling  : registered, high while in the lockout state
//   evt_cnt  : registered saturating count of fire entries
// -----------------------------------------------------------------------------
module sky130_fd_io__hvclamp_trig
  import sky130_fd_io__hvclamp_trig_pkg::*;
#(
  parameter int DEB_CYC  = DEB_CYC_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int COOL_CYC = COOL_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ramp_det,
  input  logic             force_on,
  input  logic             evt_clr,
  output logic             ogc_en,
  output logic             cooling,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam logic [DEB_W-1:0]  DEB_TGT = DEB_W'(DEB_CYC);
  localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD_CYC);
  localparam logic [COOL_W-1:0] COOL_LD = COOL_W'(COOL_CYC);

  logic              ramp_s;
  state_t            state_q, state_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [COOL_W-1:0] cool_q, cool_d;
  logic              ogc_d;
  logic              cooling_d;
  logic              fire_entry;

  sky130_fd_io__hvclamp_trig_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ramp_det),
    .q     (ramp_s)
  );

  // State, timer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      deb_q   <= '0;
      hold_q  <= '0;
      cool_q  <= '0;
      ogc_en  <= 1'b0;
      cooling <= 1'b0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      hold_q  <= hold_d;
      cool_q  <= cool_d;
      ogc_en  <= ogc_d;
      cooling <= cooling_d;
    end
  end

  // Next-state and timer logic; en low overrides every transition
  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    hold_d  = hold_q;
    cool_d  = cool_q;
    if (!en) begin
      state_d = ST_IDLE;
      deb_d   = '0;
      hold_d  = '0;
      cool_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ramp_s) begin
            // With a one-cycle debounce the first detect already qualifies
            if (DEB_TGT <= DEB_W'(1)) begin
              state_d = ST_FIRE;
              deb_d   = '0;
              hold_d  = HOLD_LD;
            end else begin
              state_d = ST_DEBOUNCE;
              deb_d   = DEB_W'(1);
            end
          end
        end
        ST_DEBOUNCE: begin
          if (ramp_s) begin
            if ((deb_q + DEB_W'(1)) >= DEB_TGT) begin
              state_d = ST_FIRE;
              deb_d   = '0;
              hold_d  = HOLD_LD;
            end else begin
              deb_d = deb_q + DEB_W'(1);
            end
          end else begin
            state_d = ST_IDLE;
            deb_d   = '0;
          end
        end
        ST_FIRE: begin
          // A detect while firing only extends the on-time
          if (ramp_s) begin
            hold_d = HOLD_LD;
          end else if (hold_q <= HOLD_W'(1)) begin
            state_d = ST_COOL;
            hold_d  = '0;
            cool_d  = COOL_LD;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        ST_COOL: begin
          // Lockout: ramp_s is deliberately ignored here
          if (cool_q <= COOL_W'(1)) begin
            state_d = ST_IDLE;
            cool_d  = '0;
          end else begin
            cool_d = cool_q - COOL_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          deb_d   = '0;
          hold_d  = '0;
          cool_d  = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so outputs register alongside it
  always_comb begin
    ogc_d      = (state_d == ST_FIRE) || force_on;
    cooling_d  = (state_d == ST_COOL);
    fire_entry = (state_d == ST_FIRE) && (state_q != ST_FIRE);
  end

`ifdef SKY130_FD_IO_HVCLAMP_TRIG_EVTCNT_EN

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] evt_cnt_q;

  // A clear coinciding with a fire entry still records that entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt_q <= '0;
    end else if (evt_clr) begin
      evt_cnt_q <= fire_entry ? CNT_W'(1) : '0;
    end else if (fire_entry) begin
      evt_cnt_q <= sat_inc(evt_cnt_q);
    end
  end

  assign evt_cnt = evt_cnt_q;

`else

  logic unused_evt;
  assign unused_evt = evt_clr ^ fire_entry;
  assign evt_cnt    = '0;

`endif

endmodule

// File: tb/tb_sky130_fd_io__hvclamp_trig.sv
module tb_sky130_fd_io__hvclamp_trig;

  localparam int DEB  = 2;
  localparam int HOLD = 64;
  localparam int COOL = 16;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;
`ifdef SKY130_FD_IO_HVCLAMP_TRIG_EVTCNT_EN
  localparam bit EVT_ON = 1'b1;
`else
  localparam bit EVT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          ramp_det;
  logic          force_on;
  logic          evt_clr;
  logic          ogc_en;
  logic          cooling;
  logic [CW-1:0] evt_cnt;

  sky130_fd_io__hvclamp_trig #(
    .DEB_CYC  (DEB),
    .HOLD_CYC (HOLD),
    .COOL_CYC (COOL),
    .CNT_W    (CW)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .ramp_det (ramp_det),
    .force_on (force_on),
    .evt_clr  (evt_clr),
    .ogc_en   (ogc_en),
    .cooling  (cooling),
    .evt_cnt  (evt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          ogc;
    logic          cool;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: deadlines in absolute edge numbers
  int unsigned edge_n;
  bit          hist[$];
  int unsigned fire_end;
  int unsigned cool_end;
  int          run;
  int          m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    edge_n   = 0;
    hist.delete();
    fire_end = 0;
    cool_end = 0;
    run      = 0;
    m_cnt    = 0;
  endfunction

  function automatic void model_edge(input bit r, input bit e, input bit rd,
                                     input bit fo, input bit clr);
    exp_t x;
    bit   rs;
    bit   fire_now;
    x = '0;
    if (!r) begin
      model_reset();
    end else begin
      edge_n++;
      // detector seen by the trigger is the sample taken two edges earlier
      rs = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
      hist.push_back(rd);
      if (hist.size() > 3) void'(hist.pop_front());
      fire_now = 1'b0;
      if (!e) begin
        fire_end = 0;
        cool_end = 0;
        run      = 0;
      end else if (fire_end != 0) begin
        if (rs) fire_end = edge_n + HOLD;
        else if (edge_n == fire_end) begin
          fire_end = 0;
          cool_end = edge_n + COOL;
        end
      end else if (cool_end != 0) begin
        if (edge_n == cool_end) cool_end = 0;
      end else if (rs) begin
        run++;
        if (run >= DEB) begin
          run      = 0;
          fire_end = edge_n + HOLD;
          fire_now = 1'b1;
        end
      end else begin
        run = 0;
      end
      if (clr) m_cnt = fire_now ? 1 : 0;
      else if (fire_now && m_cnt < MAXC) m_cnt++;
      x.ogc  = (fire_end != 0) || fo;
      x.cool = (cool_end != 0);
      x.cnt  = EVT_ON ? CW'(m_cnt) : '0;
    end
    exp_q.push_back(x);
  endfunction

  task automatic cycle(input bit r, input bit e, input bit rd, input bit fo, input bit clr);
    @(negedge clk);
    rst_n    = r;
    en       = e;
    ramp_det = rd;
    force_on = fo;
    evt_clr  = clr;
    model_edge(r, e, rd, fo, clr);
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ogc_en", {31'd0, ogc_en}, 32'd0);
    check("async_rst_cooling", {31'd0, cooling}, 32'd0);
    check("async_rst_evt_cnt", {30'd0, evt_cnt}, 32'd0);
    model_reset();
  endtask

  // Monitor: compares every output cycle against the queued expectation
  always begin
    exp_t x;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check("ogc_en", {31'd0, ogc_en}, {31'd0, x.ogc});
      check("cooling", {31'd0, cooling}, {31'd0, x.cool});
      check("evt_cnt", {30'd0, evt_cnt}, {30'd0, x.cnt});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit rl;
    rst_n = 1'b0; en = 1'b0; ramp_det = 1'b0; force_on = 1'b0; evt_clr = 1'b0;
    model_reset();
    repeat (3) cycle(0, 0, 0, 0, 0);

    // basic fire: 3-cycle ramp, hold then cool
    repeat (3) cycle(1, 1, 1, 0, 0);
    repeat (90) cycle(1, 1, 0, 0, 0);

    // single-cycle glitch is debounced away
    cycle(1, 1, 1, 0, 0);
    repeat (6) cycle(1, 1, 0, 0, 0);

    // retrigger late in hold, then a pulse during cool
    repeat (2) cycle(1, 1, 1, 0, 0);
    repeat (54) cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0);
    repeat (70) cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0);
    repeat (30) cycle(1, 1, 0, 0, 0);

    // enable dropped mid-fire, then force_on in idle
    repeat (3) cycle(1, 1, 1, 0, 0);
    repeat (10) cycle(1, 1, 0, 0, 0);
    repeat (2) cycle(1, 0, 0, 0, 0);
    repeat (3) cycle(1, 1, 0, 1, 0);
    repeat (3) cycle(1, 1, 0, 0, 0);

    // more events to reach counter saturation
    for (int k = 0; k < 2; k++) begin
      repeat (2) cycle(1, 1, 1, 0, 0);
      repeat (87) cycle(1, 1, 0, 0, 0);
    end

    // clear coincident with fire entry, then clear alone
    repeat (3) cycle(1, 1, 1, 0, 0);
    cycle(1, 1, 1, 0, 1);
    repeat (85) cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 1);
    repeat (3) cycle(1, 1, 0, 0, 0);

    // asynchronous reset mid-fire, release with detector held high
    repeat (3) cycle(1, 1, 1, 0, 0);
    repeat (5) cycle(1, 1, 0, 0, 0);
    async_reset_check();
    repeat (2) cycle(0, 1, 1, 0, 0);
    repeat (4) cycle(1, 1, 1, 0, 0);
    repeat (85) cycle(1, 1, 0, 0, 0);

    // randomized traffic
    rl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) rl = ~rl;
      cycle(1, $urandom_range(0, 63) != 0, rl, $urandom_range(0, 31) == 0,
            $urandom_range(0, 63) == 0);
    end
    repeat (3) cycle(1, 1, 0, 0, 0);

    @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
